// File: rtl/uart_bus_responder_pkg.sv
// Shared definitions for the UART bus responder: register offsets,
// CON bit positions and the state encoding used by both TX and RX FSMs.
package uart_bus_responder_pkg;

    // Byte offsets of the three registers relative to the base address
    localparam logic [31:0] OFF_TXD = 32'h0;
    localparam logic [31:0] OFF_RXD = 32'h4;
    localparam logic [31:0] OFF_CON = 32'h8;

    // CON register bit positions
    localparam int CON_TX_IE    = 0;
    localparam int CON_RX_IE    = 1;
    localparam int CON_TX_DONE  = 2;
    localparam int CON_RX_VALID = 3;
    localparam int CON_TX_BUSY  = 4;
    localparam int CON_OVERRUN  = 5;

    // Serial frame phases, shared by the transmitter and the receiver
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Zero-extend a byte onto the 32-bit read bus
    function automatic logic [31:0] zext8(input logic [7:0] b);
        return {24'h0, b};
    endfunction

endpackage

// File: rtl/uart_bus_responder_if.sv
// CPU data-bus bundle seen by the memory-mapped peripherals.
interface uart_bus_responder_if;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic        MemRead;
    logic        MemWrite;

    modport master (output Address, output Write_data, output MemRead, output MemWrite,
                    input  Read_data);
    modport slave  (input  Address, input  Write_data, input  MemRead, input  MemWrite,
                    output Read_data);
endinterface

// File: rtl/uart_bus_responder_rx_deser.sv
// UART receiver: two-flop synchronizer plus start/data/stop FSM.
// Produces the received byte and a one-clock valid pulse on a good stop bit;
// frames whose stop bit samples low are silently discarded.
module uart_rx_deser
    import uart_bus_responder_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_valid
);
    localparam int            TW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);
    // Start bit is re-checked half a bit after the falling edge
    localparam logic [TW-1:0] T_HALF = TW'(DIV / 2 - 1);

    logic [1:0]    r_sync;
    logic          r_rx_prev;
    uart_state_e   r_state, w_state_next;
    logic [TW-1:0] r_timer, w_timer_next;
    logic [2:0]    r_bit, w_bit_next;
    logic [7:0]    r_shift, w_shift_next;
    logic [7:0]    r_byte, w_byte_next;
    logic          r_valid, w_valid_next;
    logic          w_rx;

    assign w_rx    = r_sync[1];
    assign o_byte  = r_byte;
    assign o_valid = r_valid;

    // Synchronize the asynchronous line and keep the previous sample for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], i_rx};
            r_rx_prev <= w_rx;
        end
    end

    // RX FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_byte  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_byte  <= w_byte_next;
            r_valid <= w_valid_next;
        end
    end

    // RX FSM next state: mid-bit sampling, LSB first
    always_comb begin
        w_state_next = r_state;
        w_timer_next = (r_timer == T_LAST) ? '0 : r_timer + 1'b1;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_byte_next  = r_byte;
        w_valid_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_timer_next = '0;
                if (r_rx_prev && !w_rx) w_state_next = ST_START;
            end
            ST_START: begin
                if (r_timer == T_HALF) begin
                    w_timer_next = '0;
                    w_bit_next   = '0;
                    // A line that is high again at mid-start was only a glitch
                    w_state_next = w_rx ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_timer == T_LAST) begin
                    w_shift_next = {w_rx, r_shift[7:1]};
                    if (r_bit == 3'd7) w_state_next = ST_STOP;
                    else               w_bit_next   = r_bit + 3'd1;
                end
            end
            ST_STOP: begin
                if (r_timer == T_LAST) begin
                    w_state_next = ST_IDLE;
                    if (w_rx) begin
                        w_byte_next  = r_shift;
                        w_valid_next = 1'b1;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_bus_responder.sv
// Memory-mapped UART peripheral on the CPU data bus.
// TXD at BASE_ADDR, RXD at BASE_ADDR+4, CON at BASE_ADDR+8.
// Define UART_RX_FIFO_EN for a 4-entry RX FIFO; otherwise a single holding byte.
module uart_bus_responder
    import uart_bus_responder_pkg::*;
#(
    parameter int          CLK_FREQ  = 100_000_000,
    parameter int          BAUD      = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h40000018
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_bus_responder_if.slave  bus,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    output logic                 IRQ
);
    localparam int            DIV    = CLK_FREQ / BAUD;
    localparam int            TW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(DIV - 1);

    // Bus decode: exact word addresses only
    logic w_sel_txd, w_sel_rxd, w_sel_con;
    logic w_wr_txd, w_wr_con, w_rd_rxd, w_rd_con;
    logic w_unused_wdata;

    assign w_sel_txd = (bus.Address == BASE_ADDR + OFF_TXD);
    assign w_sel_rxd = (bus.Address == BASE_ADDR + OFF_RXD);
    assign w_sel_con = (bus.Address == BASE_ADDR + OFF_CON);
    assign w_wr_txd  = bus.MemWrite && w_sel_txd;
    assign w_wr_con  = bus.MemWrite && w_sel_con;
    assign w_rd_rxd  = bus.MemRead  && w_sel_rxd;
    assign w_rd_con  = bus.MemRead  && w_sel_con;
    assign w_unused_wdata = ^bus.Write_data[31:8];

    // ---------------- Transmitter ----------------
    uart_state_e   r_tx_state, w_tx_state_next;
    logic [TW-1:0] r_tx_timer, w_tx_timer_next;
    logic [2:0]    r_tx_bit, w_tx_bit_next;
    logic [7:0]    r_tx_shift, w_tx_shift_next;
    logic [7:0]    r_txd, w_txd_next;
    logic          r_tx_line, w_tx_line_next;
    logic          w_tx_done_set;
    logic          w_tx_busy;

    assign w_tx_busy = (r_tx_state != ST_IDLE);
    assign uart_tx   = r_tx_line;

    // TX FSM state register; the line flop resets high so the output idles immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_timer <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= '0;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_timer <= w_tx_timer_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx_shift <= w_tx_shift_next;
            r_txd      <= w_txd_next;
            r_tx_line  <= w_tx_line_next;
        end
    end

    // TX FSM next state; TXD writes are accepted only while idle
    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_timer_next = (r_tx_timer == T_LAST) ? '0 : r_tx_timer + 1'b1;
        w_tx_bit_next   = r_tx_bit;
        w_tx_shift_next = r_tx_shift;
        w_txd_next      = r_txd;
        w_tx_done_set   = 1'b0;
        case (r_tx_state)
            ST_IDLE: begin
                w_tx_timer_next = '0;
                if (w_wr_txd) begin
                    w_tx_state_next = ST_START;
                    w_tx_shift_next = bus.Write_data[7:0];
                    w_txd_next      = bus.Write_data[7:0];
                end
            end
            ST_START: begin
                if (r_tx_timer == T_LAST) begin
                    w_tx_state_next = ST_DATA;
                    w_tx_bit_next   = '0;
                end
            end
            ST_DATA: begin
                if (r_tx_timer == T_LAST) begin
                    w_tx_shift_next = {1'b0, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) w_tx_state_next = ST_STOP;
                    else                  w_tx_bit_next   = r_tx_bit + 3'd1;
                end
            end
            ST_STOP: begin
                if (r_tx_timer == T_LAST) begin
                    w_tx_state_next = ST_IDLE;
                    w_tx_done_set   = 1'b1;
                end
            end
            default: w_tx_state_next = ST_IDLE;
        endcase
        // Line level follows the state being entered so it changes on the same edge
        case (w_tx_state_next)
            ST_START: w_tx_line_next = 1'b0;
            ST_DATA:  w_tx_line_next = w_tx_shift_next[0];
            default:  w_tx_line_next = 1'b1;
        endcase
    end

    // ---------------- Receiver and holding storage ----------------
    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_rx_avail;
    logic [7:0] w_rx_head;
    logic       w_pop, w_push_ok, w_overrun_set;

    uart_rx_deser #(.DIV(DIV)) u_rx (
        .clk     (clk),
        .reset   (reset),
        .i_rx    (uart_rx),
        .o_byte  (w_rx_byte),
        .o_valid (w_rx_valid)
    );

    assign w_pop         = w_rd_rxd && w_rx_avail;
    assign w_overrun_set = w_rx_valid && !w_push_ok;

`ifdef UART_RX_FIFO_EN
    logic [7:0] r_fifo [4];
    logic [1:0] r_rd_ptr, r_wr_ptr;
    logic [2:0] r_count;

    assign w_rx_avail = (r_count != 3'd0);
    assign w_rx_head  = r_fifo[r_rd_ptr];
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
    assign w_push_ok  = w_rx_valid && ((r_count != 3'd4) || w_pop);

    // FIFO storage array
    always_ff @(posedge clk) begin
        if (w_push_ok) r_fifo[r_wr_ptr] <= w_rx_byte;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 2'd1;
            r_count <= r_count + {2'b0, w_push_ok} - {2'b0, w_pop};
        end
    end
`else
    logic       r_rx_full;
    logic [7:0] r_rx_data;

    assign w_rx_avail = r_rx_full;
    assign w_rx_head  = r_rx_data;
    // Pop-then-push: a byte arriving while the held one is read is kept
    assign w_push_ok  = w_rx_valid && (!r_rx_full || w_pop);

    // Single-byte holding register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_full <= 1'b0;
            r_rx_data <= '0;
        end else if (w_push_ok) begin
            r_rx_full <= 1'b1;
            r_rx_data <= w_rx_byte;
        end else if (w_pop) begin
            r_rx_full <= 1'b0;
        end
    end
`endif

    // ---------------- CON register ----------------
    logic [1:0] r_con_ie;
    logic       r_tx_done;
    logic       r_overrun;

    // Sticky status flags: a hardware set wins over a same-cycle read-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_con_ie  <= '0;
            r_tx_done <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_con) r_con_ie <= bus.Write_data[1:0];
            if (w_tx_done_set)  r_tx_done <= 1'b1;
            else if (w_rd_con)  r_tx_done <= 1'b0;
            if (w_overrun_set)  r_overrun <= 1'b1;
            else if (w_rd_con)  r_overrun <= 1'b0;
        end
    end

    assign IRQ = (r_con_ie[CON_TX_IE] & r_tx_done) | (r_con_ie[CON_RX_IE] & w_rx_avail);

    // Combinational read mux; RXD reads zero when nothing is held
    always_comb begin
        logic [31:0] w_con_val;
        w_con_val               = 32'h0;
        w_con_val[CON_TX_IE]    = r_con_ie[CON_TX_IE];
        w_con_val[CON_RX_IE]    = r_con_ie[CON_RX_IE];
        w_con_val[CON_TX_DONE]  = r_tx_done;
        w_con_val[CON_RX_VALID] = w_rx_avail;
        w_con_val[CON_TX_BUSY]  = w_tx_busy;
        w_con_val[CON_OVERRUN]  = r_overrun;
        bus.Read_data = 32'h0;
        if (bus.MemRead) begin
            if (w_sel_txd)      bus.Read_data = zext8(r_txd);
            else if (w_sel_rxd) bus.Read_data = w_rx_avail ? zext8(w_rx_head) : 32'h0;
            else if (w_sel_con) bus.Read_data = w_con_val;
        end
    end

endmodule

// File: tb/tb_uart_bus_responder.sv
// Self-checking bench for uart_bus_responder (DIV = 10).
`timescale 1ns/1ps
module tb_uart_bus_responder;
    localparam int          CLK_FREQ = 100;
    localparam int          BAUD     = 10;
    localparam int          DIV      = CLK_FREQ / BAUD;
    localparam logic [31:0] BASE     = 32'h40000018;
    localparam logic [31:0] A_TXD    = BASE;
    localparam logic [31:0] A_RXD    = BASE + 32'd4;
    localparam logic [31:0] A_CON    = BASE + 32'd8;
`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx;
    logic IRQ;

    uart_bus_responder_if bus();

    uart_bus_responder #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx),
        .IRQ     (IRQ)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboards and CON model
    logic [7:0] tx_expq[$];
    logic [7:0] rx_expq[$];
    logic [1:0] m_ie = 2'b00;
    logic       m_done = 1'b0;
    logic       m_overrun = 1'b0;

    typedef struct {
        string       name;
        int          op;      // 0 write, 1 read, 2 address driven with MemRead low
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("[%0t] %s: 0x%0h ok", $time, name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.Address = addr;
        bus.Write_data = data;
        bus.MemWrite = 1'b1;
        @(posedge clk);
        #1;
        bus.MemWrite = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus.Address = addr;
        bus.MemRead = 1'b1;
        #1;
        data = bus.Read_data;
        @(posedge clk);
        #1;
        bus.MemRead = 1'b0;
    endtask

    function automatic logic [31:0] exp_con();
        logic [31:0] v;
        v = 32'h0;
        v[1:0] = m_ie;
        v[2] = m_done;
        v[3] = (rx_expq.size() != 0);
        v[5] = m_overrun;
        return v;
    endfunction

    task automatic read_con(input string name);
        logic [31:0] d;
        logic [31:0] e;
        e = exp_con();
        bus_read(A_CON, d);
        check(name, d, e);
        m_done = 1'b0;
        m_overrun = 1'b0;
    endtask

    task automatic read_rxd(input string name);
        logic [31:0] d;
        logic [31:0] e;
        e = (rx_expq.size() != 0) ? {24'h0, rx_expq.pop_front()} : 32'h0;
        bus_read(A_RXD, d);
        check(name, d, e);
    endtask

    // Drive one frame on uart_rx and update the receive model
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(DIV);
        end
        uart_rx = stop_bit;
        tick(DIV);
        uart_rx = 1'b1;
        tick(3);
        if (stop_bit) begin
            if (rx_expq.size() < DEPTH) rx_expq.push_back(b);
            else                        m_overrun = 1'b1;
        end
    endtask

    // Decode one frame from uart_tx; returns at the edge where TX done sets
    task automatic tx_capture(input string name, output logic irq_at_stop);
        int          waited;
        logic [7:0]  b;
        logic [31:0] e;
        waited = 0;
        while (uart_tx !== 1'b0 && waited < 4 * DIV) begin
            tick(1);
            waited++;
        end
        tick(DIV / 2);
        check({name, " start bit"}, {31'h0, uart_tx}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick(DIV);
            b[i] = uart_tx;
        end
        tick(DIV);
        check({name, " stop bit"}, {31'h0, uart_tx}, 32'h1);
        irq_at_stop = IRQ;
        tick(DIV / 2);
        e = (tx_expq.size() != 0) ? {24'h0, tx_expq.pop_front()} : 32'h0;
        check({name, " byte"}, {24'h0, b}, e);
        m_done = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  pat;
        logic [7:0]  rx_bytes [5];
        logic        irq_s;
        int          bad;
        logic        expb;

        bus.Address = 32'h0;
        bus.Write_data = 32'h0;
        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b0;
        #2 reset = 1'b0;
        tick(3);
        check("reset uart_tx", {31'h0, uart_tx}, 32'h1);
        check("reset IRQ", {31'h0, IRQ}, 32'h0);
        reset = 1'b1;
        tick(2);

        // Register access table
        vecs[0]  = '{"reset CON",          1, A_CON,          32'h0,  32'h0};
        vecs[1]  = '{"reset TXD",          1, A_TXD,          32'h0,  32'h0};
        vecs[2]  = '{"reset RXD",          1, A_RXD,          32'h0,  32'h0};
        vecs[3]  = '{"write CON ff",       0, A_CON,          32'hFF, 32'h0};
        vecs[4]  = '{"CON only [1:0]",     1, A_CON,          32'h0,  32'h3};
        vecs[5]  = '{"write RXD",          0, A_RXD,          32'hAB, 32'h0};
        vecs[6]  = '{"RXD write ignored",  1, A_RXD,          32'h0,  32'h0};
        vecs[7]  = '{"MemRead low",        2, A_CON,          32'h0,  32'h0};
        vecs[8]  = '{"unaligned addr",     1, BASE + 32'd2,   32'h0,  32'h0};
        vecs[9]  = '{"addr BASE+12",       1, BASE + 32'd12,  32'h0,  32'h0};
        vecs[10] = '{"write CON 0",        0, A_CON,          32'h0,  32'h0};
        vecs[11] = '{"CON cleared",        1, A_CON,          32'h0,  32'h0};
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].op == 0) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else if (vecs[i].op == 1) begin
                bus_read(vecs[i].addr, d);
                check(vecs[i].name, d, vecs[i].exp);
            end else begin
                bus.Address = vecs[i].addr;
                bus.MemRead = 1'b0;
                #1;
                check(vecs[i].name, bus.Read_data, vecs[i].exp);
                tick(1);
            end
        end

        // 1: exact waveform of 0x55, each bit DIV clocks
        pat = 8'h55;
        bus_write(A_TXD, 32'h55);
        for (int bp = 0; bp < 10; bp++) begin
            bad = 0;
            expb = (bp == 0) ? 1'b0 : (bp == 9) ? 1'b1 : pat[bp - 1];
            for (int k = 0; k < DIV; k++) begin
                if (uart_tx !== expb) bad++;
                tick(1);
            end
            check($sformatf("tx55 bit%0d wrong clocks", bp), bad, 0);
        end
        m_done = 1'b1;
        read_con("tx55 done flag");

        // 2: TX interrupt, read-clear of done
        bus_write(A_CON, 32'h1);
        m_ie = 2'b01;
        tx_expq.push_back(8'hA3);
        bus_write(A_TXD, 32'hA3);
        tx_capture("txA3", irq_s);
        check("txA3 IRQ before done", {31'h0, irq_s}, 32'h0);
        check("txA3 IRQ at done", {31'h0, IRQ}, 32'h1);
        read_con("txA3 CON 05");
        check("txA3 IRQ after read", {31'h0, IRQ}, 32'h0);
        read_con("txA3 CON 01");

        // 3: receive with RX interrupt
        bus_write(A_CON, 32'h2);
        m_ie = 2'b10;
        send_rx(8'h3C, 1'b1);
        check("rx3C IRQ", {31'h0, IRQ}, 32'h1);
        read_con("rx3C CON valid");
        read_rxd("rx3C RXD");
        check("rx3C IRQ after pop", {31'h0, IRQ}, 32'h0);
        read_con("rx3C CON empty");

        // 4: overrun past holding capacity
        bus_write(A_CON, 32'h0);
        m_ie = 2'b00;
        rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22; rx_bytes[2] = 8'h33;
        rx_bytes[3] = 8'h44; rx_bytes[4] = 8'h55;
        for (int k = 0; k <= DEPTH; k++) send_rx(rx_bytes[k], 1'b1);
        read_con("overrun CON");
        read_con("overrun cleared");
        for (int k = 0; k < DEPTH; k++) read_rxd($sformatf("held byte %0d", k));
        read_con("holding drained");
        read_rxd("RXD empty");

        // 5: glitch and framing error
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(2 * DIV);
        read_con("glitch no byte");
        send_rx(8'h5A, 1'b0);
        tick(DIV);
        read_con("framing error no byte");
        send_rx(8'h96, 1'b1);
        read_rxd("rx after errors");

        // 6a: TXD write while busy is ignored
        tx_expq.push_back(8'hC3);
        bus_write(A_TXD, 32'hC3);
        fork
            tx_capture("txC3", irq_s);
            begin
                logic [31:0] dd;
                tick(30);
                bus_write(A_TXD, 32'h0F);
                bus_read(A_CON, dd);
                check("busy flag mid frame", dd, 32'h10);
                bus_read(A_TXD, dd);
                check("TXD unchanged", dd, 32'hC3);
            end
        join
        read_con("txC3 done");

        // 6b: reset in the middle of a frame
        bus_write(A_CON, 32'h3);
        m_ie = 2'b11;
        send_rx(8'h5A, 1'b1);
        check("IRQ before reset", {31'h0, IRQ}, 32'h1);
        bus_write(A_TXD, 32'h00);
        tick(20);
        check("tx low before reset", {31'h0, uart_tx}, 32'h0);
        reset = 1'b0;
        #1;
        check("reset uart_tx async", {31'h0, uart_tx}, 32'h1);
        check("reset IRQ async", {31'h0, IRQ}, 32'h0);
        bus_read(A_CON, d);
        check("CON during reset", d, 32'h0);
        reset = 1'b1;
        m_ie = 2'b00; m_done = 1'b0; m_overrun = 1'b0;
        rx_expq.delete();
        tx_expq.delete();
        tick(2);
        tx_expq.push_back(8'h81);
        bus_write(A_TXD, 32'h81);
        tx_capture("tx81 after reset", irq_s);
        read_con("tx81 done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
